switch_allocator: RTL

- Clocked allocation stage directly upstream of the crossbar stage; computes the `switch_sel` vector that steers the crossbar.
- Per output: wormhole lock with round-robin arbitration among input ports presenting head flits. The lock holds until the owning input's tail flit transfers.
- Drives per-input grant strobes back to the input buffers.

---
 rtl/switch_allocator_pkg.sv | 20 ++
 rtl/switch_allocator_if.sv | 28 ++
 rtl/switch_allocator_rr_arbiter.sv | 29 ++
 rtl/switch_allocator.sv | 112 +++++++++++
 4 files changed

// File: rtl/switch_allocator_pkg.sv
// Types shared between the switch allocator and the crossbar.
// Holds the port count, the port-index width and the per-output crossbar select.
package interact;

  localparam int ARITY  = 5;
  localparam int PORT_W = $clog2(ARITY);

  typedef enum logic {
    OUT_IDLE   = 1'b0,
    OUT_LOCKED = 1'b1
  } out_state_t;

  typedef struct packed {
    logic              valid;
    logic [PORT_W-1:0] src;
  } sel_entry_t;

  typedef sel_entry_t [ARITY-1:0] switch_sel_t;

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input buffers, the switch allocator and the crossbar.
interface switch_allocator_if
  import interact::*;
#(
  parameter int N_PORTS = ARITY,
  parameter int PORT_W  = $clog2(N_PORTS)
) ();

  logic [N_PORTS-1:0]             req_valid;
  logic [N_PORTS-1:0]             req_head;
  logic [N_PORTS-1:0]             req_tail;
  logic [N_PORTS-1:0][PORT_W-1:0] req_dest;
  logic [N_PORTS-1:0]             out_ready;
  logic [N_PORTS-1:0]             in_grant;
  switch_sel_t                    switch_sel;
  logic                           busy;

  modport master (
    input  req_valid, req_head, req_tail, req_dest, out_ready,
    output in_grant, switch_sel, busy
  );

  modport slave (
    output req_valid, req_head, req_tail, req_dest, out_ready,
    input  in_grant, switch_sel, busy
  );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping modulo N_PORTS.
module rr_arbiter
  import interact::*;
#(
  parameter int N_PORTS = ARITY,
  parameter int PORT_W  = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PORT_W-1:0]  ptr,
  output logic [N_PORTS-1:0] grant,
  output logic               found
);

  logic [PORT_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = PORT_W'((int'(ptr) + k) % N_PORTS);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output lock with round-robin head arbitration.
// Optional SA_BACK_TO_BACK_EN lets an output re-arbitrate in its tail cycle (no bubble).
module switch_allocator
  import interact::*;
#(
  parameter int N_PORTS = ARITY,
  parameter int PORT_W  = $clog2(N_PORTS)
) (
  input  logic            clk,
  input  logic            preset_n,
  switch_allocator_if.master sa
);

  out_state_t                     state_q [N_PORTS];
  out_state_t                     state_d [N_PORTS];
  logic [N_PORTS-1:0][PORT_W-1:0] owner_q, owner_d;
  logic [N_PORTS-1:0][PORT_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [N_PORTS-1:0]              owned;
  logic [N_PORTS-1:0]              xfer, tail_xfer, arb_en, arb_found;
  logic [N_PORTS-1:0]              grant;
  logic [N_PORTS-1:0][N_PORTS-1:0] cand, arb_grant;

  function automatic logic [PORT_W-1:0] onehot_idx(input logic [N_PORTS-1:0] oh);
    logic [PORT_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_PORTS; i++)
      if (oh[i]) r = PORT_W'(i);
    return r;
  endfunction

  function automatic logic [PORT_W-1:0] next_ptr(input logic [PORT_W-1:0] w);
    return (int'(w) == N_PORTS - 1) ? '0 : w + PORT_W'(1);
  endfunction

  // Ownership, transfers and candidates all derive from registered lock state.
  always_comb begin
    owned     = '0;
    grant     = '0;
    xfer      = '0;
    tail_xfer = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      if (state_q[o] == OUT_LOCKED) begin
        owned[owner_q[o]] = 1'b1;
        xfer[o]           = sa.req_valid[owner_q[o]] & sa.out_ready[o];
        tail_xfer[o]      = xfer[o] & sa.req_tail[owner_q[o]];
        grant[owner_q[o]] = grant[owner_q[o]] | xfer[o];
      end
    end
  end

  always_comb begin
    cand = '0;
    for (int o = 0; o < N_PORTS; o++)
      for (int i = 0; i < N_PORTS; i++)
        cand[o][i] = sa.req_valid[i] & sa.req_head[i] & ~owned[i] &
                     (sa.req_dest[i] == PORT_W'(o));
  end

  for (genvar o = 0; o < N_PORTS; o++) begin : g_arb
    rr_arbiter #(.N_PORTS(N_PORTS), .PORT_W(PORT_W)) u_arb (
      .req   (cand[o]),
      .ptr   (rr_ptr_q[o]),
      .grant (arb_grant[o]),
      .found (arb_found[o])
    );
  end

  always_ff @(posedge clk) begin
    if (!preset_n) begin
      for (int o = 0; o < N_PORTS; o++) state_q[o] <= OUT_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      for (int o = 0; o < N_PORTS; o++) state_q[o] <= state_d[o];
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // The releasing owner is already excluded from cand through owned.
  always_comb begin
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    for (int o = 0; o < N_PORTS; o++) begin
      state_d[o] = state_q[o];
`ifdef SA_BACK_TO_BACK_EN
      arb_en[o] = (state_q[o] == OUT_IDLE) | tail_xfer[o];
`else
      arb_en[o] = (state_q[o] == OUT_IDLE);
`endif
      if (tail_xfer[o]) state_d[o] = OUT_IDLE;
      if (arb_en[o] && arb_found[o]) begin
        state_d[o]  = OUT_LOCKED;
        owner_d[o]  = onehot_idx(arb_grant[o]);
        rr_ptr_d[o] = next_ptr(onehot_idx(arb_grant[o]));
      end
    end
  end

  always_comb begin
    sa.switch_sel = '0;
    sa.busy       = 1'b0;
    sa.in_grant   = grant;
    for (int o = 0; o < N_PORTS; o++) begin
      sa.switch_sel[o].valid = (state_q[o] == OUT_LOCKED);
      sa.switch_sel[o].src   = owner_q[o];
      sa.busy                = sa.busy | (state_q[o] == OUT_LOCKED);
    end
  end

endmodule
